axil_regbank: RTL

AXIL_REGBANK -- requirements
Module: axil_regbank

---
 rtl/axil_regbank.sv | 126 ++++++++++++
 1 files changed

// File: rtl/axil_regbank.sv
// axil_regbank: AXI-Lite slave register bank with byte strobes, read-only registers and per-register write pulses
module axil_regbank #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_awvalid,
  output logic                       s_awready,
  input  logic [ADDR_W-1:0]          s_awaddr,
  input  logic                       s_wvalid,
  output logic                       s_wready,
  input  logic [DATA_W-1:0]          s_wdata,
  input  logic [DATA_W/8-1:0]        s_wstrb,
  output logic                       s_bvalid,
  input  logic                       s_bready,
  output logic [1:0]                 s_bresp,
  input  logic                       s_arvalid,
  output logic                       s_arready,
  input  logic [ADDR_W-1:0]          s_araddr,
  output logic                       s_rvalid,
  input  logic                       s_rready,
  output logic [DATA_W-1:0]          s_rdata,
  output logic [1:0]                 s_rresp,
  output logic [NUM_REGS*DATA_W-1:0] reg_out,
  input  logic [NUM_REGS*DATA_W-1:0] reg_in,
  output logic [NUM_REGS-1:0]        wr_pulse
);
  localparam int SW = DATA_W / 8;
  localparam int LSB = $clog2(SW);
  localparam int IW = $clog2(NUM_REGS);
  logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0] w_data_q, w_data_d;
  logic [SW-1:0]     w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic [IW-1:0]     widx, ridx;
  logic              w_oor, r_oor, commit;
  logic [1:0]        wresp;

  assign s_awready = ~rst & ~aw_held_q;
  assign s_wready  = ~rst & ~w_held_q;
  assign s_arready = ~rst & ~rvalid_q;
  assign s_bvalid  = ~rst & bvalid_q;
  assign s_rvalid  = ~rst & rvalid_q;
  assign wr_pulse  = wr_pulse_q & {NUM_REGS{~rst}};
  assign s_bresp   = bresp_q;
  assign s_rresp   = rresp_q;
  assign s_rdata   = rdata_q;

  assign widx   = aw_addr_q[LSB +: IW];
  assign ridx   = s_araddr[LSB +: IW];
  assign w_oor  = (aw_addr_q >> (LSB + IW)) != '0;
  assign r_oor  = (s_araddr >> (LSB + IW)) != '0;
  assign commit = aw_held_q & w_held_q & ~bvalid_q;
  assign wresp  = w_oor ? 2'b11 : RO_MASK[widx] ? 2'b10 : 2'b00;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_out
    assign reg_out[i*DATA_W +: DATA_W] = regs_q[i];
  end

  // channel capture, write commit with byte strobes, and registered read response
  always_comb begin
    aw_held_d  = s_awready & s_awvalid ? 1'b1 : aw_held_q;
    aw_addr_d  = s_awready & s_awvalid ? s_awaddr : aw_addr_q;
    w_held_d   = s_wready & s_wvalid ? 1'b1 : w_held_q;
    w_data_d   = s_wready & s_wvalid ? s_wdata : w_data_q;
    w_strb_d   = s_wready & s_wvalid ? s_wstrb : w_strb_q;
    bvalid_d   = commit ? 1'b1 : (bvalid_q & s_bready) ? 1'b0 : bvalid_q;
    bresp_d    = commit ? wresp : bresp_q;
    wr_pulse_d = '0;
    regs_d     = regs_q;
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      if (wresp == 2'b00 && |w_strb_q) wr_pulse_d[widx] = 1'b1;
      for (int k = 0; k < SW; k++)
        if (wresp == 2'b00 && w_strb_q[k]) regs_d[widx][8*k +: 8] = w_data_q[8*k +: 8];
    end
    rvalid_d = (s_arready & s_arvalid) ? 1'b1 : (rvalid_q & s_rready) ? 1'b0 : rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (s_arready & s_arvalid) begin
      rresp_d = r_oor ? 2'b11 : 2'b00;
      rdata_d = r_oor ? '0 : RO_MASK[ridx] ? reg_in[ridx*DATA_W +: DATA_W] : regs_q[ridx];
    end
  end

  // state register with synchronous reset discarding any in-flight transaction
  always_ff @(posedge clk) begin
    if (rst) begin
      aw_held_q  <= 1'b0;
      aw_addr_q  <= '0;
      w_held_q   <= 1'b0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
      rvalid_q   <= 1'b0;
      rresp_q    <= 2'b00;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
      regs_q     <= '{default: '0};
    end else begin
      aw_held_q  <= aw_held_d;
      aw_addr_q  <= aw_addr_d;
      w_held_q   <= w_held_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q     <= regs_d;
    end
  end
endmodule
